// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I definitions: fetch FSM state encoding, NOP
//               encoding, default datapath width and opcode field values used
//               by the fetch stage and the decoders.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int RV_XLEN = 32;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    // Major opcode field instr[6:0]
    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;
    localparam logic [6:0] OPC_LUI      = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OPC_JALR     = 7'b110_0111;
    localparam logic [6:0] OPC_JAL      = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational next-PC selection for the fetch stage.
//   pc         in   XLEN  current PC
//   PCSrc      in   1     select PCTarget instead of pc+4
//   PCTarget   in   XLEN  branch/jump target
//   pc_plus4   out  XLEN  pc + 4 (wraps modulo 2^XLEN)
//   pc_next    out  XLEN  selected next PC
//   misaligned out  1     pc_next is not 4-byte aligned
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
    import rv32_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned
);

    // Carry out of the top bit is dropped, giving the required wrap-around.
    assign pc_plus4   = pc + XLEN'(4);
    assign pc_next    = PCSrc ? PCTarget : pc_plus4;
    assign misaligned = (pc_next[1:0] != 2'b00);

endmodule : pc_next_logic
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Holds the PC, issues one
//               request at a time to instruction memory, latches the returned
//               word and advances the PC when the instruction retires.
//   clk, rst_n              clock / async active-low reset
//   imem_req_valid/ready    request handshake, imem_addr = pc
//   imem_rsp_valid/rdata/   response channel (valid-only), err qualified by
//   imem_rsp_err            imem_rsp_valid
//   retire, PCSrc, PCTarget next-PC control, sampled in S_HOLD only
//   instr, instr_valid, pc  instruction register and its PC
//   pc_plus4                pc + 4
//   fetch_fault             sticky fault flag, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int              XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rsp_err,
    input  logic            retire,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] pc_next;
    logic            misaligned;

    pc_next_logic #(
        .XLEN (XLEN)
    ) u_pc_next_logic (
        .pc         (pc_q),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .pc_plus4   (pc_plus4),
        .pc_next    (pc_next),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        // instr keeps its previous contents on an errored access
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (retire) begin
                    instr_valid_d = 1'b0;
                    if (misaligned) begin
                        // pc is left pointing at the faulting instruction
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign fetch_fault    = fault_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Instance a uses
//               RESET_PC = 0, instance b uses RESET_PC = 32'hFFFF_FFFC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- instance a ----------------
    logic        rst_n_a;
    logic        req_valid_a, req_ready_a;
    logic [31:0] addr_a;
    logic        rsp_valid_a, rsp_err_a;
    logic [31:0] rdata_a;
    logic        retire_a, pcsrc_a;
    logic [31:0] target_a;
    logic [31:0] instr_a, pc_a, pc4_a;
    logic        ivalid_a, fault_a;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) u_dut_a (
        .clk            (clk),
        .rst_n          (rst_n_a),
        .imem_req_valid (req_valid_a),
        .imem_req_ready (req_ready_a),
        .imem_addr      (addr_a),
        .imem_rsp_valid (rsp_valid_a),
        .imem_rdata     (rdata_a),
        .imem_rsp_err   (rsp_err_a),
        .retire         (retire_a),
        .PCSrc          (pcsrc_a),
        .PCTarget       (target_a),
        .instr          (instr_a),
        .instr_valid    (ivalid_a),
        .pc             (pc_a),
        .pc_plus4       (pc4_a),
        .fetch_fault    (fault_a)
    );

    // ---------------- instance b ----------------
    logic        rst_n_b;
    logic        req_valid_b, req_ready_b;
    logic [31:0] addr_b;
    logic        rsp_valid_b, rsp_err_b;
    logic [31:0] rdata_b;
    logic        retire_b, pcsrc_b;
    logic [31:0] target_b;
    logic [31:0] instr_b, pc_b, pc4_b;
    logic        ivalid_b, fault_b;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_b (
        .clk            (clk),
        .rst_n          (rst_n_b),
        .imem_req_valid (req_valid_b),
        .imem_req_ready (req_ready_b),
        .imem_addr      (addr_b),
        .imem_rsp_valid (rsp_valid_b),
        .imem_rdata     (rdata_b),
        .imem_rsp_err   (rsp_err_b),
        .retire         (retire_b),
        .PCSrc          (pcsrc_b),
        .PCTarget       (target_b),
        .instr          (instr_b),
        .instr_valid    (ivalid_b),
        .pc             (pc_b),
        .pc_plus4       (pc4_b),
        .fetch_fault    (fault_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // From S_REQ on instance a: accept the request, answer one cycle later.
    task automatic fetch_a(input logic [31:0] word, input logic err);
        req_ready_a = 1'b1;
        step();
        req_ready_a = 1'b0;
        rsp_valid_a = 1'b1;
        rdata_a     = word;
        rsp_err_a   = err;
        step();
        rsp_valid_a = 1'b0;
        rsp_err_a   = 1'b0;
        rdata_a     = 32'hBAD0_BAD0;
    endtask

    initial begin
        rst_n_a = 1'b0; req_ready_a = 1'b0; rsp_valid_a = 1'b0; rsp_err_a = 1'b0;
        rdata_a = '0; retire_a = 1'b0; pcsrc_a = 1'b0; target_a = '0;
        rst_n_b = 1'b0; req_ready_b = 1'b0; rsp_valid_b = 1'b0; rsp_err_b = 1'b0;
        rdata_b = '0; retire_b = 1'b0; pcsrc_b = 1'b0; target_b = '0;

        step(); step();

        // Reset state
        chk("rst_req_valid", {31'd0, req_valid_a}, 32'd0);
        chk("rst_pc",        pc_a,                 32'h0000_0000);
        chk("rst_instr",     instr_a,              32'h0000_0013);
        chk("rst_ivalid",    {31'd0, ivalid_a},    32'd0);
        chk("rst_fault",     {31'd0, fault_a},     32'd0);
        chk("rst_pc_b",      pc_b,                 32'hFFFF_FFFC);

        // Basic fetch: IDLE -> REQ
        rst_n_a = 1'b1;
        step();
        chk("req1_valid", {31'd0, req_valid_a}, 32'd1);
        chk("req1_addr",  addr_a,               32'h0000_0000);
        fetch_a(32'h0050_0093, 1'b0);
        chk("hold1_instr",  instr_a,              32'h0050_0093);
        chk("hold1_ivalid", {31'd0, ivalid_a},    32'd1);
        chk("hold1_pc",     pc_a,                 32'h0000_0000);
        chk("hold1_pc4",    pc4_a,                32'h0000_0004);
        chk("hold1_noreq",  {31'd0, req_valid_a}, 32'd0);

        // Stray response in HOLD is ignored
        rsp_valid_a = 1'b1; rdata_a = 32'hDEAD_BEEF;
        step();
        rsp_valid_a = 1'b0;
        chk("stray_hold_instr", instr_a, 32'h0050_0093);

        // Sequential retire
        retire_a = 1'b1; pcsrc_a = 1'b0; target_a = 32'h0000_0100;
        step();
        retire_a = 1'b0;
        chk("ret1_req",    {31'd0, req_valid_a}, 32'd1);
        chk("ret1_addr",   addr_a,               32'h0000_0004);
        chk("ret1_pc4",    pc4_a,                32'h0000_0008);
        chk("ret1_ivalid", {31'd0, ivalid_a},    32'd0);

        // Back-pressure: ready low for 5 cycles, request and address hold
        for (int i = 0; i < 5; i++) begin
            rsp_valid_a = (i == 2);   // stray response in REQ
            rdata_a     = 32'hCAFE_F00D;
            step();
            chk("bp_valid", {31'd0, req_valid_a}, 32'd1);
            chk("bp_addr",  addr_a,               32'h0000_0004);
        end
        rsp_valid_a = 1'b0;
        chk("stray_req_instr", instr_a, 32'h0050_0093);
        req_ready_a = 1'b1;
        step();
        req_ready_a = 1'b0;
        chk("bp_wait_noreq", {31'd0, req_valid_a}, 32'd0);
        step();   // one idle WAIT cycle
        chk("wait_idle_ivalid", {31'd0, ivalid_a}, 32'd0);
        rsp_valid_a = 1'b1; rdata_a = 32'h0010_0113;
        step();
        rsp_valid_a = 1'b0;
        chk("hold2_instr", instr_a, 32'h0010_0113);
        chk("hold2_pc",    pc_a,    32'h0000_0004);

        // Taken branch to 0x100
        retire_a = 1'b1; pcsrc_a = 1'b1; target_a = 32'h0000_0100;
        step();
        retire_a = 1'b0; pcsrc_a = 1'b0;
        chk("br_pc",   pc_a,   32'h0000_0100);
        chk("br_addr", addr_a, 32'h0000_0100);
        fetch_a(32'h0000_0063, 1'b0);
        chk("br_instr", instr_a, 32'h0000_0063);

        // Misaligned target 0x102 -> fault
        retire_a = 1'b1; pcsrc_a = 1'b1; target_a = 32'h0000_0102;
        step();
        retire_a = 1'b0; pcsrc_a = 1'b0;
        chk("mis_fault",  {31'd0, fault_a},     32'd1);
        chk("mis_ivalid", {31'd0, ivalid_a},    32'd0);
        chk("mis_pc",     pc_a,                 32'h0000_0100);
        step(); step(); step();
        chk("mis_stuck_req",   {31'd0, req_valid_a}, 32'd0);
        chk("mis_stuck_fault", {31'd0, fault_a},     32'd1);

        // Reset pulse, then an errored response
        rst_n_a = 1'b0;
        #1;
        chk("rst2_fault", {31'd0, fault_a}, 32'd0);
        chk("rst2_pc",    pc_a,             32'h0000_0000);
        step();
        rst_n_a = 1'b1;
        step();
        chk("err_req", {31'd0, req_valid_a}, 32'd1);
        fetch_a(32'h1234_5678, 1'b1);
        chk("err_fault",  {31'd0, fault_a},  32'd1);
        chk("err_instr",  instr_a,           32'h0000_0013);
        chk("err_ivalid", {31'd0, ivalid_a}, 32'd0);
        req_ready_a = 1'b1;
        step(); step();
        req_ready_a = 1'b0;
        chk("err_stuck_req",   {31'd0, req_valid_a}, 32'd0);
        chk("err_stuck_fault", {31'd0, fault_a},     32'd1);

        // Reset while in S_WAIT
        rst_n_a = 1'b0;
        step();
        rst_n_a = 1'b1;
        step();
        fetch_a(32'h0030_0193, 1'b0);
        retire_a = 1'b1;
        step();
        retire_a = 1'b0;
        chk("pre_wrst_addr", addr_a, 32'h0000_0004);
        req_ready_a = 1'b1;
        step();   // now in S_WAIT
        req_ready_a = 1'b0;
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("wrst_req",    {31'd0, req_valid_a}, 32'd0);
        chk("wrst_pc",     pc_a,                 32'h0000_0000);
        chk("wrst_instr",  instr_a,              32'h0000_0013);
        chk("wrst_ivalid", {31'd0, ivalid_a},    32'd0);
        chk("wrst_fault",  {31'd0, fault_a},     32'd0);
        step();
        rst_n_a = 1'b1;
        // Late response from the abandoned access must be dropped
        rsp_valid_a = 1'b1; rdata_a = 32'hFFFF_0000;
        step();
        step();
        rsp_valid_a = 1'b0;
        chk("wrst_first_addr",  addr_a,  32'h0000_0000);
        chk("wrst_first_req",   {31'd0, req_valid_a}, 32'd1);
        chk("wrst_drop_instr",  instr_a, 32'h0000_0013);

        // Instance b: PC wrap from 0xFFFF_FFFC
        rst_n_b = 1'b1;
        step();
        chk("b_addr", addr_b, 32'hFFFF_FFFC);
        chk("b_pc4",  pc4_b,  32'h0000_0000);
        req_ready_b = 1'b1;
        step();
        req_ready_b = 1'b0;
        rsp_valid_b = 1'b1; rdata_b = 32'h0000_006F;
        step();
        rsp_valid_b = 1'b0;
        chk("b_instr", instr_b, 32'h0000_006F);
        retire_b = 1'b1; pcsrc_b = 1'b0;
        step();
        retire_b = 1'b0;
        chk("b_wrap_pc",    pc_b,                 32'h0000_0000);
        chk("b_wrap_fault", {31'd0, fault_b},     32'd0);
        chk("b_wrap_req",   {31'd0, req_valid_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
